// File: rtl/vector_checker.sv
// Self-checking vector engine for small combinational DUTs: it stores stimulus/expect/mask
// vectors, drives each stimulus, waits SETTLE cycles and compares the masked DUT response.
module vector_checker #(
  parameter int IN_W         = 4,
  parameter int OUT_W        = 1,
  parameter int DEPTH        = 16,
  parameter int SETTLE       = 1,
  parameter int STOP_ON_FAIL = 1,
  parameter int CNT_W        = 8
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           vec_we,
  input  logic [$clog2(DEPTH)-1:0]       vec_addr,
  input  logic [IN_W+2*OUT_W-1:0]        vec_wdata,
  input  logic [$clog2(DEPTH+1)-1:0]     num_vec,
  input  logic                           start,
  output logic [IN_W-1:0]                dut_in,
  input  logic [OUT_W-1:0]               dut_out,
  output logic                           busy,
  output logic                           done,
  output logic                           pass,
  output logic [CNT_W-1:0]               err_count,
  output logic [$clog2(DEPTH)-1:0]       first_fail_idx,
  output logic [OUT_W-1:0]               first_fail_got
);

  localparam int AW          = $clog2(DEPTH);
  localparam int NW          = $clog2(DEPTH + 1);
  localparam int VW          = IN_W + 2 * OUT_W;
  localparam int SW          = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam int SETTLE_LAST = (SETTLE > 0) ? SETTLE - 1 : 0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_APPLY,
    S_WAIT,
    S_CHECK,
    S_FIN
  } state_t;

  state_t             state_q;
  logic [VW-1:0]      mem_q [DEPTH];
  logic [NW-1:0]      n_q;
  logic [NW-1:0]      idx_q;
  logic [SW-1:0]      wait_q;
  logic [IN_W-1:0]    dut_in_q;
  logic               busy_q;
  logic               done_q;
  logic               pass_q;
  logic [CNT_W-1:0]   err_q;
  logic [AW-1:0]      ff_idx_q;
  logic [OUT_W-1:0]   ff_got_q;

  logic [VW-1:0]      vec_rd;
  logic [IN_W-1:0]    stim_rd;
  logic [OUT_W-1:0]   exp_rd;
  logic [OUT_W-1:0]   mask_rd;
  logic               mismatch;
  logic [CNT_W-1:0]   err_d;
  logic               last_vec;
  logic               end_run;
  logic [NW-1:0]      n_d;

  // NOTE: the vector memory carries no reset; its contents are loaded by the user and
  // survive rst_n, and leaving it out of the reset keeps it mappable onto plain RAM.
  always_ff @(posedge clk) begin
    if (vec_we && state_q == S_IDLE) begin
      mem_q[vec_addr] <= vec_wdata;
    end
  end

  // NOTE: combinational logic uses blocking '=' with every output assigned on every pass,
  // so no latches are inferred; all clocked state below is updated with '<=' only.
  always_comb begin
    vec_rd   = mem_q[idx_q[AW-1:0]];
    stim_rd  = vec_rd[VW-1 -: IN_W];
    exp_rd   = vec_rd[2*OUT_W-1 -: OUT_W];
    mask_rd  = vec_rd[OUT_W-1:0];
    mismatch = |((dut_out ^ exp_rd) & mask_rd);
    err_d    = (mismatch && err_q != '1) ? err_q + 1'b1 : err_q;
    last_vec = (idx_q + 1'b1) == n_q;
    end_run  = last_vec || ((STOP_ON_FAIL != 0) && mismatch);
    n_d      = (num_vec > NW'(DEPTH)) ? NW'(DEPTH) : num_vec;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      n_q      <= '0;
      idx_q    <= '0;
      wait_q   <= '0;
      dut_in_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
      err_q    <= '0;
      ff_idx_q <= '0;
      ff_got_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            n_q      <= n_d;
            idx_q    <= '0;
            err_q    <= '0;
            ff_idx_q <= '0;
            ff_got_q <= '0;
            pass_q   <= 1'b0;
            if (n_d == '0) begin
              // Empty run: finish immediately as a trivially passing run.
              state_q <= S_FIN;
              done_q  <= 1'b1;
              pass_q  <= 1'b1;
            end else begin
              state_q <= S_APPLY;
              busy_q  <= 1'b1;
            end
          end
        end
        S_APPLY: begin
          dut_in_q <= stim_rd;
          wait_q   <= '0;
          state_q  <= (SETTLE == 0) ? S_CHECK : S_WAIT;
        end
        S_WAIT: begin
          if (wait_q == SW'(SETTLE_LAST)) begin
            state_q <= S_CHECK;
          end else begin
            wait_q <= wait_q + 1'b1;
          end
        end
        S_CHECK: begin
          err_q <= err_d;
          // err_q only leaves zero on a mismatch, so zero here means first failure of the run.
          if (mismatch && err_q == '0) begin
            ff_idx_q <= idx_q[AW-1:0];
            ff_got_q <= dut_out;
          end
          if (end_run) begin
            state_q <= S_FIN;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            pass_q  <= (err_d == '0);
          end else begin
            idx_q   <= idx_q + 1'b1;
            state_q <= S_APPLY;
          end
        end
        S_FIN: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign dut_in         = dut_in_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign err_count      = err_q;
  assign first_fail_idx = ff_idx_q;
  assign first_fail_got = ff_got_q;

endmodule

// File: tb/tb_vector_checker.sv
// Directed bench for vector_checker: xorfour channels with stop/continue/saturating/zero-settle
// configurations, plus a sillyfunction channel exercising ignored start and write while busy.
module tb_vector_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  // Channels 0..2: xorfour (0: stop on fail, 1: run all, 2: run all, CNT_W=2, SETTLE=0)
  logic [2:0] start_v;
  logic [2:0] we_v;
  logic [3:0] addr;
  logic [5:0] wdata;
  logic [4:0] nvec;
  wire  [3:0] din_v [3];
  wire  [2:0] dout_v;
  wire  [2:0] busy_v;
  wire  [2:0] done_v;
  wire  [2:0] pass_v;
  wire  [3:0] ffidx_v [3];
  wire  [2:0] ffgot_v;
  wire  [7:0] err_a;
  wire  [7:0] err_b;
  wire  [1:0] err_c;

  assign dout_v = {^din_v[2], ^din_v[1], ^din_v[0]};

  // Channel D: sillyfunction, y = ~b~c | a~b with {a,b,c} = dut_in
  logic       start_d, we_d;
  logic [2:0] addr_d;
  logic [4:0] wdata_d;
  logic [3:0] nvec_d;
  wire  [2:0] din_d;
  wire        dout_d;
  wire        busy_d, done_d, pass_d;
  wire  [7:0] err_d;
  wire  [2:0] ffidx_d;
  wire        ffgot_d;

  assign dout_d = (~din_d[1] & ~din_d[0]) | (din_d[2] & ~din_d[1]);

  vector_checker #(.IN_W(4), .OUT_W(1), .DEPTH(16), .SETTLE(1), .STOP_ON_FAIL(1), .CNT_W(8)) u_a (
    .clk(clk), .rst_n(rst_n), .vec_we(we_v[0]), .vec_addr(addr), .vec_wdata(wdata),
    .num_vec(nvec), .start(start_v[0]), .dut_in(din_v[0]), .dut_out(dout_v[0]),
    .busy(busy_v[0]), .done(done_v[0]), .pass(pass_v[0]), .err_count(err_a),
    .first_fail_idx(ffidx_v[0]), .first_fail_got(ffgot_v[0]));

  vector_checker #(.IN_W(4), .OUT_W(1), .DEPTH(16), .SETTLE(1), .STOP_ON_FAIL(0), .CNT_W(8)) u_b (
    .clk(clk), .rst_n(rst_n), .vec_we(we_v[1]), .vec_addr(addr), .vec_wdata(wdata),
    .num_vec(nvec), .start(start_v[1]), .dut_in(din_v[1]), .dut_out(dout_v[1]),
    .busy(busy_v[1]), .done(done_v[1]), .pass(pass_v[1]), .err_count(err_b),
    .first_fail_idx(ffidx_v[1]), .first_fail_got(ffgot_v[1]));

  vector_checker #(.IN_W(4), .OUT_W(1), .DEPTH(16), .SETTLE(0), .STOP_ON_FAIL(0), .CNT_W(2)) u_c (
    .clk(clk), .rst_n(rst_n), .vec_we(we_v[2]), .vec_addr(addr), .vec_wdata(wdata),
    .num_vec(nvec), .start(start_v[2]), .dut_in(din_v[2]), .dut_out(dout_v[2]),
    .busy(busy_v[2]), .done(done_v[2]), .pass(pass_v[2]), .err_count(err_c),
    .first_fail_idx(ffidx_v[2]), .first_fail_got(ffgot_v[2]));

  vector_checker #(.IN_W(3), .OUT_W(1), .DEPTH(8), .SETTLE(1), .STOP_ON_FAIL(1), .CNT_W(8)) u_d (
    .clk(clk), .rst_n(rst_n), .vec_we(we_d), .vec_addr(addr_d), .vec_wdata(wdata_d),
    .num_vec(nvec_d), .start(start_d), .dut_in(din_d), .dut_out(dout_d),
    .busy(busy_d), .done(done_d), .pass(pass_d), .err_count(err_d),
    .first_fail_idx(ffidx_d), .first_fail_got(ffgot_d));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] err_of(input int k);
    case (k)
      0:       return 32'(err_a);
      1:       return 32'(err_b);
      default: return 32'(err_c);
    endcase
  endfunction

  task automatic write_vec(input int k, input logic [3:0] a, input logic [5:0] d);
    @(negedge clk);
    addr     = a;
    wdata    = d;
    we_v[k]  = 1'b1;
    @(negedge clk);
    we_v[k]  = 1'b0;
  endtask

  // Loads stim=i, expect=parity(i) (inverted where flip is set), mask cleared where dc is set.
  task automatic load_xor(input int k, input logic [15:0] flip, input logic [15:0] dc);
    logic [3:0] s;
    for (int i = 0; i < 16; i++) begin
      s = 4'(i);
      write_vec(k, s, {s, (^s) ^ flip[i], ~dc[i]});
    end
  endtask

  // Pulses start (optionally with a write of addr/wdata in the same cycle); dc is the cycle,
  // counted from the start cycle, in which done is seen (-1 if never); nd counts done pulses.
  task automatic run(input int k, input logic [4:0] n, input logic wr, output int dc, output int nd);
    @(negedge clk);
    nvec       = n;
    start_v[k] = 1'b1;
    if (wr) we_v[k] = 1'b1;
    @(posedge clk);
    #1;
    start_v[k] = 1'b0;
    we_v[k]    = 1'b0;
    dc = -1;
    nd = 0;
    for (int c = 1; c <= 200; c++) begin
      if (done_v[k]) begin
        nd++;
        if (dc < 0) dc = c;
      end
      if (dc >= 0 && c >= dc + 4) break;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic run_d(input logic disturb, input logic [7:0] tbl, output int dc, output int nd);
    @(negedge clk);
    nvec_d  = 4'd8;
    start_d = 1'b1;
    @(posedge clk);
    #1;
    start_d = 1'b0;
    dc = -1;
    nd = 0;
    for (int c = 1; c <= 200; c++) begin
      if (disturb && c == 4) start_d = 1'b1;
      if (disturb && c == 5) begin
        start_d = 1'b0;
        addr_d  = 3'd3;
        wdata_d = {3'd3, ~tbl[3], 1'b1};
        we_d    = 1'b1;
      end
      if (disturb && c == 6) we_d = 1'b0;
      if (done_d) begin
        nd++;
        if (dc < 0) dc = c;
      end
      if (dc >= 0 && c >= dc + 4) break;
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int dc, nd, ndone;
    logic [7:0] silly_tbl;
    silly_tbl = 8'h31;  // abc=000,100,101 -> 1; others -> 0
    rst_n   = 1'b0;
    start_v = '0;
    we_v    = '0;
    addr    = '0;
    wdata   = '0;
    nvec    = '0;
    start_d = 1'b0;
    we_d    = 1'b0;
    addr_d  = '0;
    wdata_d = '0;
    nvec_d  = '0;
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("rst_busy%0d", k),  32'(busy_v[k]),  0);
      check($sformatf("rst_done%0d", k),  32'(done_v[k]),  0);
      check($sformatf("rst_pass%0d", k),  32'(pass_v[k]),  0);
      check($sformatf("rst_err%0d", k),   err_of(k),       0);
      check($sformatf("rst_din%0d", k),   32'(din_v[k]),   0);
      check($sformatf("rst_ffidx%0d", k), 32'(ffidx_v[k]), 0);
      check($sformatf("rst_ffgot%0d", k), 32'(ffgot_v[k]), 0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    // Clean xorfour run
    load_xor(0, 16'h0000, 16'h0000);
    run(0, 5'd16, 1'b0, dc, nd);
    check("a_clean_done_cyc", 32'(dc), 49);
    check("a_clean_ndone", 32'(nd), 1);
    check("a_clean_pass", 32'(pass_v[0]), 1);
    check("a_clean_err", err_of(0), 0);
    check("a_clean_din_hold", 32'(din_v[0]), 15);
    check("a_clean_busy", 32'(busy_v[0]), 0);

    // Vector 5 expect flipped, stop on first fail
    load_xor(0, 16'h0020, 16'h0000);
    run(0, 5'd16, 1'b0, dc, nd);
    check("a_stop_done_cyc", 32'(dc), 19);
    check("a_stop_ndone", 32'(nd), 1);
    check("a_stop_pass", 32'(pass_v[0]), 0);
    check("a_stop_err", err_of(0), 1);
    check("a_stop_ffidx", 32'(ffidx_v[0]), 5);
    check("a_stop_ffgot", 32'(ffgot_v[0]), 0);
    check("a_stop_din", 32'(din_v[0]), 5);

    // Same corruption masked off
    load_xor(0, 16'h0020, 16'h0020);
    run(0, 5'd16, 1'b0, dc, nd);
    check("a_mask_done_cyc", 32'(dc), 49);
    check("a_mask_pass", 32'(pass_v[0]), 1);
    check("a_mask_err", err_of(0), 0);

    // Empty run and oversize num_vec
    run(0, 5'd0, 1'b0, dc, nd);
    check("a_n0_done_cyc", 32'(dc), 1);
    check("a_n0_pass", 32'(pass_v[0]), 1);
    check("a_n0_err", err_of(0), 0);
    run(0, 5'd20, 1'b0, dc, nd);
    check("a_n20_done_cyc", 32'(dc), 49);
    check("a_n20_pass", 32'(pass_v[0]), 1);

    // Write of a corrupted vector 0 in the start cycle is seen by that run
    addr  = 4'd0;
    wdata = {4'd0, 1'b1, 1'b1};
    run(0, 5'd16, 1'b1, dc, nd);
    check("a_wrstart_done_cyc", 32'(dc), 4);
    check("a_wrstart_pass", 32'(pass_v[0]), 0);
    check("a_wrstart_err", err_of(0), 1);
    check("a_wrstart_ffidx", 32'(ffidx_v[0]), 0);

    // Run-all with faults at 2, 7, 11
    load_xor(1, 16'h0884, 16'h0000);
    run(1, 5'd16, 1'b0, dc, nd);
    check("b_all_done_cyc", 32'(dc), 49);
    check("b_all_err", err_of(1), 3);
    check("b_all_ffidx", 32'(ffidx_v[1]), 2);
    check("b_all_ffgot", 32'(ffgot_v[1]), 1);
    check("b_all_pass", 32'(pass_v[1]), 0);
    check("b_all_din", 32'(din_v[1]), 15);

    // CNT_W=2, SETTLE=0, four faults at 1, 4, 9, 13 -> saturates at 3
    load_xor(2, 16'h2212, 16'h0000);
    run(2, 5'd16, 1'b0, dc, nd);
    check("c_sat_done_cyc", 32'(dc), 33);
    check("c_sat_err", err_of(2), 3);
    check("c_sat_ffidx", 32'(ffidx_v[2]), 1);
    check("c_sat_ffgot", 32'(ffgot_v[2]), 1);
    check("c_sat_pass", 32'(pass_v[2]), 0);

    // sillyfunction: extra start and write while busy are ignored
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      addr_d  = 3'(i);
      wdata_d = {3'(i), silly_tbl[i], 1'b1};
      we_d    = 1'b1;
      @(negedge clk);
      we_d    = 1'b0;
    end
    run_d(1'b1, silly_tbl, dc, nd);
    check("d_busy_done_cyc", 32'(dc), 25);
    check("d_busy_ndone", 32'(nd), 1);
    check("d_busy_pass", 32'(pass_d), 1);
    check("d_busy_err", 32'(err_d), 0);
    check("d_busy_din", 32'(din_d), 7);
    run_d(1'b0, silly_tbl, dc, nd);
    check("d_rerun_done_cyc", 32'(dc), 25);
    check("d_rerun_pass", 32'(pass_d), 1);
    check("d_rerun_err", 32'(err_d), 0);

    // Reset in cycle 10 of a run on channel B (vector 2 still corrupted)
    @(negedge clk);
    nvec       = 5'd16;
    start_v[1] = 1'b1;
    @(posedge clk);
    #1;
    start_v[1] = 1'b0;
    repeat (9) begin
      @(posedge clk);
      #1;
    end
    check("b_mid_busy", 32'(busy_v[1]), 1);
    check("b_mid_err", err_of(1), 1);
    rst_n = 1'b0;
    #1;
    check("b_rst_busy", 32'(busy_v[1]), 0);
    check("b_rst_din", 32'(din_v[1]), 0);
    check("b_rst_err", err_of(1), 0);
    check("b_rst_ffidx", 32'(ffidx_v[1]), 0);
    ndone = 0;
    repeat (2) begin
      @(posedge clk);
      #1;
      ndone += int'(done_v[1]);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) begin
      @(posedge clk);
      #1;
      ndone += int'(done_v[1]);
    end
    check("b_rst_no_done", 32'(ndone), 0);
    write_vec(1, 4'd2, {4'd2, 1'b1, 1'b1});
    write_vec(1, 4'd7, {4'd7, 1'b1, 1'b1});
    write_vec(1, 4'd11, {4'd11, 1'b1, 1'b1});
    run(1, 5'd16, 1'b0, dc, nd);
    check("b_after_done_cyc", 32'(dc), 49);
    check("b_after_pass", 32'(pass_v[1]), 1);
    check("b_after_err", err_of(1), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
